// File: rtl/de0_pio_pkg.sv
// rtl/de0_pio_pkg.sv - shared constants and edge helper for the DE0 input PIO
// Purpose: register addresses, edge-type encodings and the per-bit edge rule.
// Ports: none (package).
package de0_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // Per-bit edge flags from the current and one-cycle-old synchronised inputs.
   function automatic logic [31:0] edge_bits(input logic [31:0] cur,
                                             input logic [31:0] prev,
                                             input int          edge_type);
      case (edge_type)
         EDGE_FALL: return ~cur & prev;
         EDGE_ANY:  return cur ^ prev;
         default:   return cur & ~prev;
      endcase
   endfunction

endpackage

// File: rtl/de0_pio_in_edge_if.sv
// rtl/de0_pio_in_edge_if.sv - Avalon-MM slave bus bundle for the input PIO
// Purpose: groups the register-access signals of the PIO.
// Ports: address[1:0], chipselect, write_n, writedata[31:0] (master->slave),
//        readdata[31:0] (slave->master).
interface de0_pio_in_edge_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/pio_sync_chain.sv
// rtl/pio_sync_chain.sv - multi-flop synchroniser for an asynchronous input bus
// Purpose: passes each bit through SYNC_STAGES flops; q is the last stage.
// Ports: clk, reset_n (async, active-low, clears to 0), d[WIDTH-1:0] async in,
//        q[WIDTH-1:0] synchronised out.
module pio_sync_chain #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [SYNC_STAGES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/de0_pio_in_edge.sv
// rtl/de0_pio_in_edge.sv - input PIO with edge capture and maskable interrupt
// Purpose: synchronises in_port, captures per-bit edges into sticky bits,
//          exposes data/irqmask/edgecapture registers and a level irq.
// Ports: clk, reset_n (async, active-low), avs (Avalon slave: address,
//        chipselect, write_n, writedata, readdata), in_port[WIDTH-1:0], irq.
module de0_pio_in_edge
   import de0_pio_pkg::*;
#(
   parameter int               WIDTH          = 8,
   parameter int               SYNC_STAGES    = 2,
   parameter int               EDGE_TYPE      = EDGE_RISE,
   parameter logic [WIDTH-1:0] IRQ_MASK_RESET = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   de0_pio_in_edge_if.slave avs,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   // Detection stays off until the synchroniser and prev_q hold real input
   // samples, so inputs already high at reset exit do not look like edges.
   localparam int WARM_CYCLES = SYNC_STAGES + 1;
   localparam int CNT_W       = $clog2(WARM_CYCLES + 1);

   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] clear_bits;
   logic [WIDTH-1:0] edgecapture;
   logic [WIDTH-1:0] irqmask;
   logic [CNT_W-1:0] warm_cnt;
   logic             warm_done;
   logic             write_en;
   logic             unused_wdata;

   pio_sync_chain #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (in_port),
      .q       (sync_q)
   );

   assign warm_done = (warm_cnt == CNT_W'(WARM_CYCLES));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         warm_cnt <= '0;
      end else if (!warm_done) begin
         warm_cnt <= warm_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= '0;
      end else begin
         prev_q <= sync_q;
      end
   end

   assign edge_hit = warm_done
                   ? WIDTH'(edge_bits(32'(sync_q), 32'(prev_q), EDGE_TYPE))
                   : '0;

   assign write_en   = avs.chipselect & ~avs.write_n;
   assign clear_bits = (write_en && avs.address == ADDR_EDGECAP)
                     ? avs.writedata[WIDTH-1:0] : '0;

   // OR-ing the new edges in after the clear makes a coincident edge win.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edgecapture <= '0;
      end else begin
         edgecapture <= (edgecapture & ~clear_bits) | edge_hit;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask <= IRQ_MASK_RESET;
      end else if (write_en && avs.address == ADDR_IRQMASK) begin
         irqmask <= avs.writedata[WIDTH-1:0];
      end
   end

   // Read mux is registered every cycle from address alone; reads never alter state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         avs.readdata <= '0;
      end else begin
         case (avs.address)
            ADDR_DATA:    avs.readdata <= 32'(sync_q);
            ADDR_IRQMASK: avs.readdata <= 32'(irqmask);
            ADDR_EDGECAP: avs.readdata <= 32'(edgecapture);
            default:      avs.readdata <= '0;
         endcase
      end
   end

   assign irq = |(edgecapture & irqmask);

   assign unused_wdata = ^avs.writedata;

endmodule

// File: tb/tb_de0_pio_in_edge.sv
// tb/tb_de0_pio_in_edge.sv - self-checking bench for de0_pio_in_edge
module tb_de0_pio_in_edge;
   import de0_pio_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [7:0]  in_a;
   logic [31:0] in_b;
   logic [4:0]  in_c;
   logic        irq_a, irq_b, irq_c;

   de0_pio_in_edge_if if_a ();
   de0_pio_in_edge_if if_b ();
   de0_pio_in_edge_if if_c ();

   de0_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISE),
                     .IRQ_MASK_RESET(8'h00)) dut_a (
      .clk(clk), .reset_n(reset_n), .avs(if_a), .in_port(in_a), .irq(irq_a));

   de0_pio_in_edge #(.WIDTH(32), .SYNC_STAGES(3), .EDGE_TYPE(EDGE_ANY),
                     .IRQ_MASK_RESET(32'h0)) dut_b (
      .clk(clk), .reset_n(reset_n), .avs(if_b), .in_port(in_b), .irq(irq_b));

   de0_pio_in_edge #(.WIDTH(5), .SYNC_STAGES(4), .EDGE_TYPE(EDGE_FALL),
                     .IRQ_MASK_RESET(5'h15)) dut_c (
      .clk(clk), .reset_n(reset_n), .avs(if_c), .in_port(in_c), .irq(irq_c));

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic set_bus(input logic [1:0] a, input logic cs, input logic wn,
                          input logic [31:0] wd);
      if_a.address = a; if_a.chipselect = cs; if_a.write_n = wn; if_a.writedata = wd;
      if_b.address = a; if_b.chipselect = cs; if_b.write_n = wn; if_b.writedata = wd;
      if_c.address = a; if_c.chipselect = cs; if_c.write_n = wn; if_c.writedata = wd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed vectors for the 8-bit rising-edge instance, one row per clock.
   typedef struct {
      logic [1:0]  addr;
      logic        cs;
      logic        wn;
      logic [31:0] wd;
      logic [7:0]  in_v;
      logic [31:0] rd;
      logic        irq_v;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic [1:0] a, input logic cs, input logic wn,
                              input logic [31:0] wd, input logic [7:0] in_v,
                              input logic [31:0] rd, input logic irq_v);
      vec_t r;
      r.addr = a; r.cs = cs; r.wn = wn; r.wd = wd; r.in_v = in_v; r.rd = rd; r.irq_v = irq_v;
      return r;
   endfunction

   // Reference model: input history per instance, edges judged from the
   // documented input latency (a value sampled at edge k is seen at edge k+S).
   logic [31:0] hist [3][512];
   logic [31:0] m_cap  [3];
   logic [31:0] m_mask [3];

   function automatic logic [31:0] wmask(input int d);
      return (d == 0) ? 32'h0000_00FF : (d == 1) ? 32'hFFFF_FFFF : 32'h0000_001F;
   endfunction
   function automatic int stages(input int d);
      return (d == 0) ? 2 : (d == 1) ? 3 : 4;
   endfunction
   function automatic int etype(input int d);
      return (d == 0) ? EDGE_RISE : (d == 1) ? EDGE_ANY : EDGE_FALL;
   endfunction
   function automatic logic [31:0] mrst(input int d);
      return (d == 2) ? 32'h15 : 32'h0;
   endfunction
   function automatic logic [31:0] h(input int d, input int i);
      return (i < 1) ? 32'h0 : hist[d][i];
   endfunction

   logic [31:0] exp_rd  [3];
   logic        exp_irq [3];

   task automatic model_edge(input int d, input int c, input logic [1:0] a,
                             input logic cs, input logic wn, input logic [31:0] wd);
      logic [31:0] nw, od, det, clr;
      int s;
      s = stages(d);
      case (a)
         2'd0:    exp_rd[d] = h(d, c - s);
         2'd2:    exp_rd[d] = m_mask[d];
         2'd3:    exp_rd[d] = m_cap[d];
         default: exp_rd[d] = 32'h0;
      endcase
      det = 32'h0;
      if (c >= s + 2) begin
         nw = h(d, c - s);
         od = h(d, c - s - 1);
         if (etype(d) == EDGE_RISE)      det = nw & ~od;
         else if (etype(d) == EDGE_FALL) det = od & ~nw;
         else                            det = nw ^ od;
      end
      clr = (cs && !wn && a == 2'd3) ? wd : 32'h0;
      m_cap[d] = ((m_cap[d] & ~clr) | det) & wmask(d);
      if (cs && !wn && a == 2'd2) m_mask[d] = wd & wmask(d);
      exp_irq[d] = |(m_cap[d] & m_mask[d]);
   endtask

   initial begin
      logic [31:0] rds [3];
      logic        irqs [3];
      logic [31:0] in_val, wd;
      logic [1:0]  a;
      logic        cs, wn;
      int          c;

      reset_n = 1'b0;
      in_a = 8'hA5; in_b = 32'hDEAD_BEEF; in_c = 5'h0A;
      set_bus(2'd0, 1'b0, 1'b1, 32'h0);
      repeat (3) tick();
      check("reset_rd_a", 0, if_a.readdata, 32'h0);
      check("reset_irq_a", 0, {31'h0, irq_a}, 32'h0);
      check("reset_irq_c", 0, {31'h0, irq_c}, 32'h0);
      reset_n = 1'b1;

      // Read path, warm-up, rising capture + clear, set-wins collision, mask.
      tbl.push_back(v(2'd0, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h00, 1'b0));
      tbl.push_back(v(2'd0, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h00, 1'b0));
      tbl.push_back(v(2'd0, 1'b0, 1'b1, 32'h0,        8'hA5, 32'hA5, 1'b0));
      tbl.push_back(v(2'd1, 1'b1, 1'b1, 32'h0,        8'hA5, 32'h00, 1'b0));
      tbl.push_back(v(2'd3, 1'b1, 1'b1, 32'h0,        8'hA5, 32'h00, 1'b0));
      tbl.push_back(v(2'd1, 1'b1, 1'b0, 32'hFF,       8'hA5, 32'h00, 1'b0));
      tbl.push_back(v(2'd0, 1'b1, 1'b0, 32'h00,       8'hA5, 32'hA5, 1'b0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(v(2'd3, 1'b0, 1'b1, 32'h0,     8'hA5, 32'h00, 1'b0));
      tbl.push_back(v(2'd2, 1'b1, 1'b0, 32'hFFFFFF01, 8'hA5, 32'h00, 1'b0));
      tbl.push_back(v(2'd2, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h01, 1'b0));
      tbl.push_back(v(2'd3, 1'b0, 1'b1, 32'h0,        8'hA4, 32'h00, 1'b0));
      tbl.push_back(v(2'd3, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h00, 1'b0));
      tbl.push_back(v(2'd3, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h00, 1'b0));
      tbl.push_back(v(2'd3, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h00, 1'b1));
      tbl.push_back(v(2'd3, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h01, 1'b1));
      tbl.push_back(v(2'd3, 1'b1, 1'b0, 32'h01,       8'hA5, 32'h01, 1'b0));
      tbl.push_back(v(2'd3, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h00, 1'b0));
      tbl.push_back(v(2'd3, 1'b0, 1'b1, 32'h0,        8'hA1, 32'h00, 1'b0));
      tbl.push_back(v(2'd3, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h00, 1'b0));
      tbl.push_back(v(2'd3, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h00, 1'b0));
      tbl.push_back(v(2'd3, 1'b1, 1'b0, 32'h04,       8'hA5, 32'h00, 1'b0));
      tbl.push_back(v(2'd3, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h04, 1'b0));
      tbl.push_back(v(2'd2, 1'b1, 1'b0, 32'h04,       8'hA5, 32'h01, 1'b1));
      tbl.push_back(v(2'd2, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h04, 1'b1));

      foreach (tbl[i]) begin
         set_bus(tbl[i].addr, tbl[i].cs, tbl[i].wn, tbl[i].wd);
         in_a = tbl[i].in_v;
         tick();
         check("tbl_rd", i, if_a.readdata, tbl[i].rd);
         check("tbl_irq", i, {31'h0, irq_a}, {31'h0, tbl[i].irq_v});
      end

      // Wide read, irqmask width truncation, any-edge capture while masked.
      set_bus(2'd0, 1'b0, 1'b1, 32'h0);
      tick();
      check("wide_data", 0, if_b.readdata, 32'hDEAD_BEEF);
      set_bus(2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF);
      tick();
      set_bus(2'd2, 1'b0, 1'b1, 32'h0);
      tick();
      check("mask_w32", 0, if_b.readdata, 32'hFFFF_FFFF);
      check("mask_w5", 0, if_c.readdata, 32'h0000_001F);
      check("mask_w8", 0, if_a.readdata, 32'h0000_00FF);
      set_bus(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF);
      tick();
      set_bus(2'd2, 1'b1, 1'b0, 32'h0);
      tick();
      set_bus(2'd0, 1'b0, 1'b1, 32'h0);
      in_b = 32'hDEAD_BEEF ^ 32'h8;
      repeat (4) tick();
      check("any_masked_irq", 0, {31'h0, irq_b}, 32'h0);
      set_bus(2'd3, 1'b0, 1'b1, 32'h0);
      tick();
      check("any_cap", 0, if_b.readdata, 32'h8);
      set_bus(2'd2, 1'b1, 1'b0, 32'h8);
      tick();
      check("unmask_irq", 0, {31'h0, irq_b}, 32'h1);

      // Asynchronous reset mid-operation, checked between clock edges.
      reset_n = 1'b0;
      #1;
      check("async_irq_b", 0, {31'h0, irq_b}, 32'h0);
      check("async_rd_b", 0, if_b.readdata, 32'h0);
      set_bus(2'd0, 1'b0, 1'b1, 32'h0);
      repeat (2) tick();
      reset_n = 1'b1;

      // Randomised phase against the history model for all three instances.
      for (int d = 0; d < 3; d++) begin
         m_cap[d]  = 32'h0;
         m_mask[d] = mrst(d);
      end
      c = 0;
      for (int n = 0; n < 300; n++) begin
         in_val = $urandom;
         a      = 2'($urandom_range(0, 3));
         cs     = 1'($urandom_range(0, 1));
         wn     = ($urandom_range(0, 3) != 0);
         wd     = $urandom;
         in_a = in_val[7:0]; in_b = in_val; in_c = in_val[4:0];
         set_bus(a, cs, wn, wd);
         c++;
         for (int d = 0; d < 3; d++) begin
            hist[d][c] = in_val & wmask(d);
            model_edge(d, c, a, cs, wn, wd);
         end
         tick();
         rds[0] = if_a.readdata; rds[1] = if_b.readdata; rds[2] = if_c.readdata;
         irqs[0] = irq_a; irqs[1] = irq_b; irqs[2] = irq_c;
         for (int d = 0; d < 3; d++) begin
            check($sformatf("rand_rd%0d", d), n, rds[d], exp_rd[d]);
            check($sformatf("rand_irq%0d", d), n, {31'h0, irqs[d]}, {31'h0, exp_irq[d]});
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
